mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port round-robin arbiter/sequencer for the single-port 256x16 data/instruction memory.
- Port 0 is instruction fetch; port 1 is data load/store.
- Each access is latched, driven to the memory for one cycle, and acknowledged with registered read data.
- Sits between the core's fetch and LSU units and the memory instance.

Parameters:
- DATA_W, 16, data width of requesters and memory.
- ADDR_W, 16, address width of requesters and memory.
- DEPTH, 256, number of implemented memory words; used by the range check.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 request; held with addr/we/wdata stable until p0_ack
- p0_we  input  1  port 0 write enable (1=store, 0=load)
- p0_addr  input  ADDR_W  port 0 word address
- p0_wdata  input  DATA_W  port 0 write data
- p0_ack  output  1  one-cycle completion pulse
- p0_rdata  output  DATA_W  read data, valid while p0_ack=1, held until next port-0 read
- p0_err  output  1  range error, pulses with p0_ack (feature only)
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata, p1_err: as port 0, for port 1
- mem_addr  output  ADDR_W  memory address
- mem_data_in  output  DATA_W  memory write data
- mem_we  output  1  memory write enable
- mem_data_out  input  DATA_W  memory read data; combinational from mem_addr
- busy  output  1  high in GRANT or DONE

Behaviour:
- States:
  - IDLE -> GRANT when p0_req|p1_req.
  - GRANT -> DONE, always.
  - DONE -> IDLE, always.
  - IDLE holds when no request.
- Arbitration (IDLE only):
  - Single requester wins.
  - If both request, the port not equal to last_grant wins.
  - On the IDLE->GRANT edge, latch winner id, addr, we and wdata into lat_* registers, and update last_grant.
- GRANT:
  - mem_addr=lat_addr, mem_data_in=lat_wdata, mem_we=lat_we.
  - The memory writes on the closing edge.
  - On the same edge, capture mem_data_out into the winner's rdata register, but only if lat_we=0.
  - The other port's rdata is unchanged.
  - Set winner ack register to 1.
- DONE:
  - Winner ack=1 for exactly this cycle.
  - Requests are not sampled.
  - Requester may drop req or present a new request on the following edge.
- Outside GRANT: mem_we=0, mem_addr=0, mem_data_in=0.
- Latency:
  - Req first seen in IDLE at cycle N -> mem access in N+1 -> ack in N+2.
  - Throughput is one access per 3 cycles.
- Requests arriving in GRANT/DONE wait and are not lost, because req is held until ack.
- Write then read of the same address by the same or the other port returns the new data (sequential accesses).
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie).
  - p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, p0_err=p1_err=0, busy=0.
  - mem_we=0, mem_addr=0, mem_data_in=0.
- Reset mid-operation:
  - rst during GRANT aborts the access.
  - mem_we=0 from the next cycle; the write on the rst edge still occurs because mem_we is decoded from GRANT state.
  - No ack is issued; requesters must reissue.
- Address width: mem_addr passes lat_addr unmodified; the memory uses the low bits.

Optional Feature:
- Macro: MEM_ARB_RANGE_CHECK_EN.
- Defined: in GRANT, if lat_addr >= DEPTH, force mem_we=0 and capture rdata=0; the winner's err pulses together with its ack.
- Undefined: no check; p0_err and p1_err are tied to 0; the address passes through.

Test Plan:
- Reset then p0 read addr 0x0005 (mem=0x1234) -> p0_ack high exactly 2 cycles after first IDLE sample; p0_rdata=0x1234; mem_we stays 0.
- p1 write 0xBEEF to 0x0010, then p0 read 0x0010 -> mem_we=1 for one cycle with mem_addr=0x0010; p0_rdata=0xBEEF.
- p0 and p1 request simultaneously out of reset, held continuously -> grant order p0, p1, p0, p1; acks alternate every 3 cycles.
- rst asserted in GRANT of a p1 read -> no p1_ack; all outputs at reset values next cycle; p1 request re-serviced after rst drops.
- p0 and p1 reads back-to-back -> p1_rdata is unchanged when p0 completes, and vice versa.
- With MEM_ARB_RANGE_CHECK_EN: p1 write to 0x0100 -> mem_we never asserted; p1_ack=p1_err=1 in the same cycle; p1 read 0x0100 returns rdata=0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port round-robin arbiter/sequencer for a single-port memory.
//            Port 0 is instruction fetch, port 1 is data load/store. Each
//            access is latched, driven to the memory for one cycle (GRANT)
//            and acknowledged in the following cycle (DONE) with registered
//            read data. One access every three cycles.
//
// Ports    : clk, rst           - clock, synchronous active-high reset
//            pN_req/we/addr/wdata - requester N inputs (held until pN_ack)
//            pN_ack             - one-cycle completion pulse
//            pN_rdata           - read data, held until the next port-N read
//            pN_err             - out-of-range pulse alongside pN_ack
//            mem_addr/mem_data_in/mem_we - memory drive, only non-zero in GRANT
//            mem_data_out       - memory read data (combinational from mem_addr)
//            busy               - high while an access is in flight
//
// Config   : `define MEM_ARB_RANGE_CHECK_EN enables the address range check
//            (addresses >= DEPTH are not written, read as 0 and flag err).
//            Without it pN_err stay 0 and every address passes through.
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out,

    output logic              busy
);

`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam logic c_RANGE_EN = 1'b1;
`else
    localparam logic c_RANGE_EN = 1'b0;
`endif

    localparam logic [31:0] c_DEPTH = DEPTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;   // port served most recently
    logic                r_lat_id;       // port owning the current access
    logic                r_lat_we;
    logic [ADDR_W-1:0]   r_lat_addr;
    logic [DATA_W-1:0]   r_lat_wdata;
    logic                r_p0_ack;
    logic                r_p1_ack;
    logic                r_p0_err;
    logic                r_p1_err;
    logic [DATA_W-1:0]   r_p0_rdata;
    logic [DATA_W-1:0]   r_p1_rdata;

    logic                w_grant;
    logic                w_win;          // arbitration winner in IDLE
    logic                w_oob;          // latched address outside memory
    logic [DATA_W-1:0]   w_rdata;

    // A lone requester wins; on a tie the port not served last time wins.
    assign w_win   = (p0_req && p1_req) ? ~r_last_grant : p1_req;

    // Constant-folds to 0 when the range check is compiled out.
    assign w_oob   = c_RANGE_EN && (32'(r_lat_addr) >= c_DEPTH);

    assign w_rdata = w_oob ? '0 : mem_data_out;

    // Memory drive is decoded from the GRANT state so a reset asserted in
    // GRANT still lets that cycle's write land on the reset edge.
    assign w_grant     = (r_state == S_GRANT);
    assign mem_addr    = w_grant ? r_lat_addr  : '0;
    assign mem_data_in = w_grant ? r_lat_wdata : '0;
    assign mem_we      = w_grant & r_lat_we & ~w_oob;
    assign busy        = (r_state != S_IDLE);

    assign p0_ack   = r_p0_ack;
    assign p1_ack   = r_p1_ack;
    assign p0_err   = r_p0_err;
    assign p1_err   = r_p1_err;
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_lat_id     <= 1'b0;
            r_lat_we     <= 1'b0;
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            // Acks and errors are single-cycle pulses.
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            r_p0_err <= 1'b0;
            r_p1_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_lat_id     <= w_win;
                        r_last_grant <= w_win;
                        r_lat_we     <= w_win ? p1_we    : p0_we;
                        r_lat_addr   <= w_win ? p1_addr  : p0_addr;
                        r_lat_wdata  <= w_win ? p1_wdata : p0_wdata;
                        r_state      <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    if (r_lat_id == 1'b0) begin
                        r_p0_ack <= 1'b1;
                        r_p0_err <= w_oob;
                        if (!r_lat_we) begin
                            r_p0_rdata <= w_rdata;
                        end
                    end else begin
                        r_p1_ack <= 1'b1;
                        r_p1_err <= w_oob;
                        if (!r_lat_we) begin
                            r_p1_rdata <= w_rdata;
                        end
                    end
                    r_state <= S_DONE;
                end

                // Requests are ignored here; the requester sees its ack
                // during this cycle and may drop or change req.
                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
